mmul_index_arbiter: RTL and testbench
=====================================

# mmul_index_arbiter

Index sequencer and dimension checker for the matrix-multiply datapath. It statically checks that A (RA×CA) and B (RB×CB) are conformable. It then walks the (i, j, k) index space in row-major order, one multiply-accumulate step per enabled clock. The MAC datapath consumes i, j, k, fire, acc_first and acc_last to compute C[i][j] += A[i][k]·B[k][j]. The block holds no matrix data.

## Interface
- RA, default 2: rows of A.
- CA, default 2: columns of A (inner dimension n).
- RB, default 2: rows of B; must equal CA.
- CB, default 2: columns of B.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  advance one step this cycle when legal.
- clear  in  1  synchronous restart: indices to 0, completed to 0.
- valid  out  1  dimensions legal: CA==RB and all dimensions ≥1. Constant.
- i  out  IW_I=max(1,$clog2(RA))  current row of A/C.
- j  out  IW_J=max(1,$clog2(CB))  current column of B/C.
- k  out  IW_K=max(1,$clog2(CA))  current inner index.
- fire  out  1  combinational: enable & valid & ~completed & ~clear.
- acc_first  out  1  fire & (k==0): datapath loads the product instead of accumulating.
- acc_last  out  1  fire & (k==CA-1): C[i][j] is final after this step.
- completed  out  1  registered, sticky; all RA·CB·CA steps consumed.

## Operation
- Let n = CA. The step sequence for k is 0..n-1, innermost; j is 0..CB-1, middle; i is 0..RA-1, outer.
- On each clk edge with fire=1:
  - if k<n-1: k++;
  - else k←0, and if j<CB-1: j++;
  - else j←0, and if i<RA-1: i++;
  - else i←0 and completed←1.
- fire=0: all state holds.
- clear=1 (sync): i, j, k ← 0 and completed ← 0. clear overrides enable in the same cycle; fire is 0 while clear is high.
- valid=0: fire is never asserted, indices stay 0, completed stays 0.
- Index arithmetic is unsigned. Compares use full parameter values, so non-power-of-two dimensions wrap exactly at the bound.
- After completed=1, indices rest at (0,0,0). enable is ignored until clear or reset.

## Timing
- Reset (rst_n low, async): i=j=k=0, completed=0. fire, acc_first and acc_last are therefore 0 whenever enable=0.
- i, j and k are registered and present the step being executed in the current cycle. The datapath samples products on the same edge that advances the indices.
- Total latency is exactly RA·CB·CA fire cycles from reset or clear. completed rises on the edge consuming step (RA-1, CB-1, n-1).
- Gaps in enable stall the sequence without losing steps.
- Reset mid-operation aborts immediately. There is no partial-completion indication.

## Configuration
- MMUL_ARB_PROGRESS_EN defined: adds output step_cnt, width $clog2(RA·CB·CA+1).
  - Increments on fire; reset and clear set it to 0.
  - Saturates at RA·CB·CA when completed.
- Undefined: the port is absent and no counter logic is built.

## Structure
- Package mmul_pkg holds:
  - function idx_w(dim), returning max(1,$clog2(dim));
  - function dims_ok(RA,CA,RB,CB);
  - localparam-friendly step-count helper.
- Sub-module mmul_validator (pure combinational, parameters only, output valid) is instantiated inside. The counter/wrap FSM lives in the top.
- The FSM has two states, RUN and DONE, encoded by completed.

## Test plan
- RA=2, CA=RB=3, CB=2, enable held high:
  - 12 fires;
  - sequence (0,0,0),(0,0,1),(0,0,2),(0,1,0)…(1,1,2);
  - acc_last on fires 3, 6, 9, 12;
  - completed=1 after the 12th edge;
  - fire=0 afterwards.
- Same configuration, enable toggled 1,0,1,0…: indices hold on low cycles; completed after 12 high cycles (24 cycles).
- CA=3, RB=2: valid=0; enable high for 20 cycles gives fire=0, indices (0,0,0), completed=0.
- RA=CA=RB=CB=1: first fire has acc_first=acc_last=1, and completed=1 after 1 cycle.
- Reset and clear on the 2×3×2 configuration:
  - rst_n pulsed low mid-run at step 7: async return to (0,0,0), completed=0;
  - clear asserted after completion restarts a full 12-step sequence.
- With MMUL_ARB_PROGRESS_EN: step_cnt reads 12 at completion and stays 12 under continued enable.

Source files
------------

// File: rtl/mmul_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mmul_pkg : shared types and constant helpers for the matmul index arbiter
// Revision : 1.0
// ---------------------------------------------------------------------------
package mmul_pkg;

  // DONE is entered on the final step and left only by clear or reset.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  function automatic bit dims_ok(input int ra, input int ca, input int rb, input int cb);
    return (ca == rb) && (ra >= 1) && (ca >= 1) && (rb >= 1) && (cb >= 1);
  endfunction

  function automatic int total_steps(input int ra, input int cb, input int ca);
    return ra * cb * ca;
  endfunction

  function automatic int cnt_w(input int ra, input int cb, input int ca);
    int t;
    t = total_steps(ra, cb, ca);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmul_validator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mmul_validator : static conformability check of the A and B dimensions
// Revision : 1.0
// ---------------------------------------------------------------------------
module mmul_validator
  import mmul_pkg::*;
#(
  parameter int RA = 2,
  parameter int CA = 2,
  parameter int RB = 2,
  parameter int CB = 2
) (
  output logic valid
);

  assign valid = dims_ok(RA, CA, RB, CB);

endmodule
`default_nettype wire

// File: rtl/mmul_index_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mmul_index_arbiter : row-major (i, j, k) step sequencer for the MAC datapath
// Optional step counter output enabled by MMUL_ARB_PROGRESS_EN.
// Revision : 1.0
// ---------------------------------------------------------------------------
module mmul_index_arbiter
  import mmul_pkg::*;
#(
  parameter int RA = 2,
  parameter int CA = 2,
  parameter int RB = 2,
  parameter int CB = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        clear,
  output logic                        valid,
  output logic [idx_w(RA)-1:0]        i,
  output logic [idx_w(CB)-1:0]        j,
  output logic [idx_w(CA)-1:0]        k,
  output logic                        fire,
  output logic                        acc_first,
  output logic                        acc_last,
  output logic                        completed
`ifdef MMUL_ARB_PROGRESS_EN
  ,
  output logic [cnt_w(RA,CB,CA)-1:0]  step_cnt
`endif
);

  localparam int IW_I = idx_w(RA);
  localparam int IW_J = idx_w(CB);
  localparam int IW_K = idx_w(CA);

  // Last-index values clamp at 0 so degenerate dimensions still elaborate.
  localparam int IL = (RA > 1) ? RA - 1 : 0;
  localparam int JL = (CB > 1) ? CB - 1 : 0;
  localparam int KL = (CA > 1) ? CA - 1 : 0;
  localparam logic [IW_I-1:0] I_LAST = IL[IW_I-1:0];
  localparam logic [IW_J-1:0] J_LAST = JL[IW_J-1:0];
  localparam logic [IW_K-1:0] K_LAST = KL[IW_K-1:0];

  arb_state_e        state_q, state_d;
  logic [IW_I-1:0]   i_q, i_d;
  logic [IW_J-1:0]   j_q, j_d;
  logic [IW_K-1:0]   k_q, k_d;

  mmul_validator #(
    .RA (RA),
    .CA (CA),
    .RB (RB),
    .CB (CB)
  ) u_validator (
    .valid (valid)
  );

  assign fire      = enable & valid & (state_q == ST_RUN) & ~clear;
  assign acc_first = fire & (k_q == '0);
  assign acc_last  = fire & (k_q == K_LAST);
  assign completed = (state_q == ST_DONE);
  assign i         = i_q;
  assign j         = j_q;
  assign k         = k_q;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    if (clear) begin
      state_d = ST_RUN;
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
    end else if (fire) begin
      if (k_q != K_LAST) begin
        k_d = k_q + IW_K'(1);
      end else begin
        k_d = '0;
        if (j_q != J_LAST) begin
          j_d = j_q + IW_J'(1);
        end else begin
          j_d = '0;
          if (i_q != I_LAST) begin
            i_d = i_q + IW_I'(1);
          end else begin
            i_d     = '0;
            state_d = ST_DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

`ifdef MMUL_ARB_PROGRESS_EN
  localparam int CW    = cnt_w(RA, CB, CA);
  localparam int TOTAL = total_steps(RA, CB, CA);
  localparam logic [CW-1:0] CNT_MAX = TOTAL[CW-1:0];

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (fire && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign step_cnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmul_index_arbiter.sv
`default_nettype none
// Self-checking bench: 2x3x2 sequencer against a step-count model, plus an
// illegal-dimension instance and a 1x1x1 instance.
module tb_mmul_index_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: RA=2, CA=RB=3, CB=2
  logic       en_a = 1'b0, clr_a = 1'b0;
  logic       valid_a, fire_a, af_a, al_a, cmp_a;
  logic [0:0] i_a, j_a;
  logic [1:0] k_a;
  // Instance B: CA=3, RB=2 (non-conformable)
  logic       en_b = 1'b0, clr_b = 1'b0;
  logic       valid_b, fire_b, af_b, al_b, cmp_b;
  logic [0:0] i_b, j_b;
  logic [1:0] k_b;
  // Instance C: 1x1x1
  logic       en_c = 1'b0, clr_c = 1'b0;
  logic       valid_c, fire_c, af_c, al_c, cmp_c;
  logic [0:0] i_c, j_c, k_c;
`ifdef MMUL_ARB_PROGRESS_EN
  logic [3:0] sc_a, sc_b;
  logic [0:0] sc_c;
`endif

  mmul_index_arbiter #(.RA(2), .CA(3), .RB(3), .CB(2)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .clear(clr_a), .valid(valid_a),
    .i(i_a), .j(j_a), .k(k_a), .fire(fire_a), .acc_first(af_a), .acc_last(al_a),
    .completed(cmp_a)
`ifdef MMUL_ARB_PROGRESS_EN
    , .step_cnt(sc_a)
`endif
  );

  mmul_index_arbiter #(.RA(2), .CA(3), .RB(2), .CB(2)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .clear(clr_b), .valid(valid_b),
    .i(i_b), .j(j_b), .k(k_b), .fire(fire_b), .acc_first(af_b), .acc_last(al_b),
    .completed(cmp_b)
`ifdef MMUL_ARB_PROGRESS_EN
    , .step_cnt(sc_b)
`endif
  );

  mmul_index_arbiter #(.RA(1), .CA(1), .RB(1), .CB(1)) u_c (
    .clk(clk), .rst_n(rst_n), .enable(en_c), .clear(clr_c), .valid(valid_c),
    .i(i_c), .j(j_c), .k(k_c), .fire(fire_c), .acc_first(af_c), .acc_last(al_c),
    .completed(cmp_c)
`ifdef MMUL_ARB_PROGRESS_EN
    , .step_cnt(sc_c)
`endif
  );

  int tests = 0;
  int fails = 0;
  int sa    = 0;   // steps consumed by instance A since reset/clear
  int nfire = 0;

  localparam int N_A = 3, CB_A = 2, TOT_A = 12;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected indices from the number of steps already consumed.
  function automatic int exp_k(input int s); return (s >= TOT_A) ? 0 : s % N_A; endfunction
  function automatic int exp_j(input int s); return (s >= TOT_A) ? 0 : (s / N_A) % CB_A; endfunction
  function automatic int exp_i(input int s); return (s >= TOT_A) ? 0 : s / (N_A * CB_A); endfunction

  task automatic cycle_a(input logic en, input logic clr);
    logic ef;
    @(negedge clk);
    en_a  = en;
    clr_a = clr;
    #1;
    ef = en && !clr && (sa < TOT_A);
    chk("a_valid", valid_a, 1);
    chk("a_fire", fire_a, ef);
    chk("a_i", i_a, exp_i(sa));
    chk("a_j", j_a, exp_j(sa));
    chk("a_k", k_a, exp_k(sa));
    chk("a_acc_first", af_a, ef && (exp_k(sa) == 0));
    chk("a_acc_last", al_a, ef && (exp_k(sa) == N_A - 1));
    chk("a_completed", cmp_a, sa >= TOT_A);
`ifdef MMUL_ARB_PROGRESS_EN
    chk("a_step_cnt", sc_a, sa);
`endif
    @(posedge clk);
    if (clr) sa = 0;
    else if (ef) begin
      sa++;
      nfire++;
    end
  endtask

  initial begin
    // Reset state with all enables low
    #2;
    chk("rst_a_i", i_a, 0);
    chk("rst_a_j", j_a, 0);
    chk("rst_a_k", k_a, 0);
    chk("rst_a_cmp", cmp_a, 0);
    chk("rst_a_fire", fire_a, 0);
    chk("rst_c_cmp", cmp_c, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Enable held high: 12 fires then idle at completion
    nfire = 0;
    for (int n = 0; n < 16; n++) cycle_a(1'b1, 1'b0);
    chk("held_fires", nfire, 12);
    chk("held_done", cmp_a, 1);

    // Clear after completion, then toggled enable over 24 cycles
    cycle_a(1'b1, 1'b1);
    nfire = 0;
    for (int n = 0; n < 24; n++) cycle_a(((n % 2) == 0), 1'b0);
    chk("tog_fires", nfire, 12);
    chk("tog_done", cmp_a, 1);

    // Randomized enable with occasional clear
    cycle_a(1'b0, 1'b1);
    for (int n = 0; n < 120; n++)
      cycle_a(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));

    // Mid-run async reset at step 7
    cycle_a(1'b0, 1'b1);
    while (sa < 7) cycle_a(1'b1, 1'b0);
    @(negedge clk);
    en_a  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_i", i_a, 0);
    chk("mrst_j", j_a, 0);
    chk("mrst_k", k_a, 0);
    chk("mrst_cmp", cmp_a, 0);
    sa = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 14; n++) cycle_a(1'b1, 1'b0);
    chk("post_rst_done", cmp_a, 1);
    @(negedge clk);
    en_a = 1'b0;

    // Non-conformable dimensions: nothing moves
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      en_b = 1'b1;
      #1;
      chk("b_valid", valid_b, 0);
      chk("b_fire", fire_b, 0);
      chk("b_idx", {29'd0, i_b, j_b, k_b}, 0);
      chk("b_acc", {af_b, al_b}, 0);
      chk("b_cmp", cmp_b, 0);
    end
    @(negedge clk);
    en_b = 1'b0;

    // 1x1x1: single step that is both first and last
    @(negedge clk);
    en_c = 1'b1;
    #1;
    chk("c_fire", fire_c, 1);
    chk("c_acc_first", af_c, 1);
    chk("c_acc_last", al_c, 1);
    chk("c_cmp0", cmp_c, 0);
    @(negedge clk);
    #1;
    chk("c_cmp1", cmp_c, 1);
    chk("c_fire_after", fire_c, 0);
`ifdef MMUL_ARB_PROGRESS_EN
    chk("c_step_cnt", sc_c, 1);
`endif
    @(negedge clk);
    clr_c = 1'b1;
    #1;
    chk("c_clr_fire", fire_c, 0);
    @(negedge clk);
    clr_c = 1'b0;
    #1;
    chk("c_clr_cmp", cmp_c, 0);
    chk("c_refire", fire_c, 1);
    @(negedge clk);
    en_c = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
